// File: rtl/xor_2_pkg.sv
// Shared definitions for the xor_2 compare/parity primitive: default sizes
// and the mismatch-counter operation decode.
package xor_2_pkg;

  localparam int XOR_2_WIDTH_DEF = 1;
  localparam int XOR_2_CNT_W_DEF = 16;

  // What the mismatch counter does on a given clock edge.
  typedef enum logic [1:0] {
    CNT_HOLD  = 2'd0,
    CNT_CLEAR = 2'd1,
    CNT_INC   = 2'd2
  } cnt_op_e;

  // Clear has priority over increment when both are requested together.
  function automatic cnt_op_e cnt_op(input logic clr, input logic hit);
    if (clr) return CNT_CLEAR;
    if (hit) return CNT_INC;
    return CNT_HOLD;
  endfunction

endpackage : xor_2_pkg

// File: rtl/xor_2_sat_cnt.sv
// Saturating up-counter with synchronous clear. Clear beats increment, and
// once the counter reaches all-ones it sticks there instead of wrapping.
module xor_2_sat_cnt
  import xor_2_pkg::*;
#(
  parameter int CNT_W = XOR_2_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  cnt_op_e op;

  assign op = cnt_op(clr, inc);

  // Count register: clear, saturating increment, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      unique case (op)
        CNT_CLEAR: cnt <= '0;
        CNT_INC:   if (cnt != '1) cnt <= cnt + CNT_W'(1);
        default:   cnt <= cnt;
      endcase
    end
  end

endmodule : xor_2_sat_cnt

// File: rtl/xor_2.sv
// Bitwise two-input XOR. The combinational result c depends only on a and b,
// so it works with clk/rst_n left unconnected. Registered status (copy of the
// result, its parity, an any-bit-differs flag) and a saturating count of
// mismatch cycles are provided for debug.
module xor_2
  import xor_2_pkg::*;
#(
  parameter int WIDTH = XOR_2_WIDTH_DEF,
  parameter int CNT_W = XOR_2_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_q,
  output logic             parity_q,
  output logic             diff_q,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] mis_cnt
);

  logic [WIDTH-1:0] diff_vec;
  logic             any_diff;

  // Pure continuous path; X/Z on the operands flows straight through.
  assign diff_vec = a ^ b;
  assign c        = diff_vec;
  assign any_diff = |diff_vec;

  // Status registers: result copy, its parity and the differ flag.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; reset is asynchronous so status clears the moment
  // rst_n falls, without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q      <= '0;
      parity_q <= 1'b0;
      diff_q   <= 1'b0;
    end else begin
      c_q      <= diff_vec;
      parity_q <= ^diff_vec;
      diff_q   <= any_diff;
    end
  end

  xor_2_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_sat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (any_diff),
    .cnt   (mis_cnt)
  );

endmodule : xor_2

// File: tb/tb_xor_2.sv
// Directed bench for xor_2: default build (WIDTH=1, CNT_W=16), a 4-bit build
// and a 2-bit-counter build share one clock and reset.
`timescale 1ns/1ps
module tb_xor_2;

  logic clk;
  logic rst_n;

  // WIDTH=1, CNT_W=16
  logic        a1, b1, c1, cq1, par1, diff1, clr1;
  logic [15:0] cnt1;
  // WIDTH=4, CNT_W=16
  logic [3:0]  a4, b4, c4, cq4;
  logic        par4, diff4, clr4;
  logic [15:0] cnt4;
  // WIDTH=1, CNT_W=2
  logic        a2, b2, c2, cq2, par2, diff2, clr2;
  logic [1:0]  cnt2;

  int n_cmp;
  int n_bad;

  xor_2 #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .c_q(cq1),
    .parity_q(par1), .diff_q(diff1), .clr_cnt(clr1), .mis_cnt(cnt1)
  );

  xor_2 #(.WIDTH(4), .CNT_W(16)) u_w4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c(c4), .c_q(cq4),
    .parity_q(par4), .diff_q(diff4), .clr_cnt(clr4), .mis_cnt(cnt4)
  );

  xor_2 #(.WIDTH(1), .CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .c(c2), .c_q(cq2),
    .parity_q(par2), .diff_q(diff2), .clr_cnt(clr2), .mis_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Truth table for test 1: {a,b} -> c
  logic [1:0] tt_in  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic       tt_out [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    {a1, b1, clr1} = '0;
    {a4, b4} = '0; clr4 = 1'b0;
    {a2, b2, clr2} = '0;

    // Combinational truth table while held in reset (no clocked behaviour).
    for (int i = 0; i < 4; i++) begin
      #10;
      {a1, b1} = tt_in[i];
      #0.1;
      check($sformatf("tt_c_%0d", i), 32'(c1), 32'(tt_out[i]));
    end

    // Reset values of every registered output.
    check("rst_cq1",   32'(cq1),   32'd0);
    check("rst_par1",  32'(par1),  32'd0);
    check("rst_diff1", 32'(diff1), 32'd0);
    check("rst_cnt1",  32'(cnt1),  32'd0);
    check("rst_cq4",   32'(cq4),   32'd0);
    check("rst_cnt2",  32'(cnt2),  32'd0);

    // Release reset away from an edge.
    {a1, b1} = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Registered path.
    a1 = 1'b1; b1 = 1'b0;
    step();
    check("reg_cq_10",   32'(cq1),   32'd1);
    check("reg_diff_10", 32'(diff1), 32'd1);
    check("reg_par_10",  32'(par1),  32'd1);
    a1 = 1'b1; b1 = 1'b1;
    step();
    check("reg_cq_11",   32'(cq1),   32'd0);
    check("reg_diff_11", 32'(diff1), 32'd0);
    check("reg_par_11",  32'(par1),  32'd0);
    check("cnt_after_reg", 32'(cnt1), 32'd1);

    // 4-bit build.
    a4 = 4'b1010; b4 = 4'b0110;
    #1;
    check("w4_c", 32'(c4), 32'hC);
    step();
    check("w4_cq",   32'(cq4),   32'hC);
    check("w4_par",  32'(par4),  32'd0);
    check("w4_diff", 32'(diff4), 32'd1);
    a4 = 4'b0111; b4 = 4'b0111;
    step();
    check("w4_cq_eq",   32'(cq4),   32'h0);
    check("w4_diff_eq", 32'(diff4), 32'd0);
    a4 = 4'b1000; b4 = 4'b0000;
    step();
    check("w4_par_odd", 32'(par4), 32'd1);

    // Counter: clear, 5 mismatches, 3 matches.
    clr1 = 1'b1;
    step();
    check("cnt_clr", 32'(cnt1), 32'd0);
    clr1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a1 = i[0]; b1 = ~i[0];
      step();
    end
    check("cnt_5", 32'(cnt1), 32'd5);
    for (int i = 0; i < 3; i++) begin
      a1 = i[0]; b1 = i[0];
      step();
    end
    check("cnt_hold", 32'(cnt1), 32'd5);
    clr1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    step();
    check("cnt_clr_wins", 32'(cnt1), 32'd0);
    clr1 = 1'b0;
    step();
    check("cnt_restart", 32'(cnt1), 32'd1);

    // Saturation with a 2-bit counter.
    a2 = 1'b1; b2 = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("sat_reach", 32'(cnt2), 32'd3);
    for (int i = 0; i < 3; i++) step();
    check("sat_hold", 32'(cnt2), 32'd3);
    clr2 = 1'b1;
    step();
    check("sat_clr", 32'(cnt2), 32'd0);
    clr2 = 1'b0;

    // Async reset between edges; c keeps tracking the operands.
    a1 = 1'b1; b1 = 1'b0;
    step();
    check("pre_rst_cq", 32'(cq1), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cq",   32'(cq1),   32'd0);
    check("arst_par",  32'(par1),  32'd0);
    check("arst_diff", 32'(diff1), 32'd0);
    check("arst_cnt",  32'(cnt1),  32'd0);
    check("arst_cnt4", 32'(cnt4),  32'd0);
    check("arst_c_10", 32'(c1),    32'd1);
    a1 = 1'b0; b1 = 1'b0;
    #0.5;
    check("arst_c_00", 32'(c1), 32'd0);
    a1 = 1'b0; b1 = 1'b1;
    #0.5;
    check("arst_c_01", 32'(c1), 32'd1);
    rst_n = 1'b1;
    step();
    check("rel_cq",  32'(cq1),  32'd1);
    check("rel_cnt", 32'(cnt1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule : tb_xor_2
